// File: rtl/game_session_ctrl_pkg.sv
// Shared Breakout session types: FSM state enum, BCD digit type and the
// 7-segment decoder used by the top-level HEX displays.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SERVE       = 3'd1,
    PLAY        = 3'd2,
    LEVEL_CLEAR = 3'd3,
    GAME_OVER   = 3'd4,
    VICTORY     = 3'd5
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  // Active-low segments {g,f,e,d,c,b,a}; non-decimal codes blank the digit.
  function automatic logic [6:0] digit_to_seg(input bcd_digit_t d);
    logic [6:0] seg;
    case (d)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/game_session_ctrl_if.sv
// Session-controller bundle: collision/button inputs in, session status out.
// Events are level-free 1-cycle pulses (ball_died, brick_destroyed, refresh_tick)
// sampled on the next clk edge; start/launch are levels, edge-detected inside.
interface game_session_ctrl_if #(parameter int SCORE_DIGITS = 3);
  import game_pkg::*;

  logic                      refresh_tick;
  logic                      start;
  logic                      launch;
  logic                      ball_died;
  logic                      brick_destroyed;
  state_t                    state;
  logic                      field_reset;
  logic                      serve_hold;
  logic [2:0]                lives;
  logic [3:0]                level;
  logic [4*SCORE_DIGITS-1:0] score_bcd;
  logic                      game_over_on;
  logic                      victory_on;
  logic                      level_clear_on;
  logic [4*SCORE_DIGITS-1:0] high_score_bcd;

  modport master (
    output refresh_tick, start, launch, ball_died, brick_destroyed,
    input  state, field_reset, serve_hold, lives, level, score_bcd,
           game_over_on, victory_on, level_clear_on, high_score_bcd
  );

  modport slave (
    input  refresh_tick, start, launch, ball_died, brick_destroyed,
    output state, field_reset, serve_hold, lives, level, score_bcd,
           game_over_on, victory_on, level_clear_on, high_score_bcd
  );

endinterface

// File: rtl/game_session_ctrl_bcd_score_counter.sv
// Packed BCD score register: saturating add of a single-digit value with
// ripple carry, synchronous clear, and magnitude compare against cmp_bcd.
module bcd_score_counter
  import game_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                add_en,
  input  bcd_digit_t          add_val,
  input  logic [4*DIGITS-1:0] cmp_bcd,
  output logic [4*DIGITS-1:0] score_bcd,
  output logic                gt
);

  logic [4*DIGITS-1:0] sum_bcd;
  logic [4:0]          acc;
  logic [3:0]          carry;
  logic                carry_out;

  always_comb begin
    sum_bcd = '0;
    acc     = '0;
    carry   = add_val;
    for (int i = 0; i < DIGITS; i++) begin
      acc = {1'b0, score_bcd[4*i +: 4]} + {1'b0, carry};
      if (acc > 5'd9) begin
        sum_bcd[4*i +: 4] = 4'(acc - 5'd10);
        carry             = 4'd1;
      end else begin
        sum_bcd[4*i +: 4] = acc[3:0];
        carry             = 4'd0;
      end
    end
    carry_out = (carry != 4'd0);
  end

  // A carry out of the top digit pins the score at all nines.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      score_bcd <= '0;
    end else if (add_en) begin
      score_bcd <= carry_out ? {DIGITS{4'h9}} : sum_bcd;
    end
  end

  // Valid BCD orders the same way as its packed binary image.
  assign gt = (score_bcd > cmp_bcd);

endmodule

// File: rtl/game_session_ctrl.sv
// Breakout session sequencer: lives, levels, BCD score and timed banners.
// Optional HIGH_SCORE_EN adds a power-up-only best-score register.
module game_session_ctrl
  import game_pkg::*;
#(
  parameter int LIVES            = 3,
  parameter int BRICKS_PER_LEVEL = 28,
  parameter int NUM_LEVELS       = 3,
  parameter int BANNER_TICKS     = 360,
  parameter int SCORE_DIGITS     = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  game_session_ctrl_if.slave bus
);

  localparam int TW = $clog2(BANNER_TICKS + 1);
  localparam int SW = 4 * SCORE_DIGITS;

  state_t         state_q;
  logic [2:0]     lives_q;
  logic [3:0]     level_q;
  logic [5:0]     bricks_q;
  logic [TW-1:0]  timer_q;
  logic           field_reset_q, serve_hold_q;
  logic           game_over_q, victory_q, clear_q;
  logic           start_prev, start_evt, launch_prev, launch_evt;
  logic [SW-1:0]  score;
  logic [SW-1:0]  best_cmp;
  logic           score_gt;

  logic in_banner, banner_done, brick_hit, last_brick, score_clr;

  assign in_banner   = (state_q == LEVEL_CLEAR) || (state_q == GAME_OVER) ||
                       (state_q == VICTORY);
  assign banner_done = in_banner && bus.refresh_tick &&
                       (timer_q == TW'(BANNER_TICKS - 1));
  assign brick_hit   = (state_q == PLAY) && bus.brick_destroyed && (bricks_q != 6'd0);
  assign last_brick  = brick_hit && (bricks_q == 6'd1);
  assign score_clr   = banner_done && (state_q != LEVEL_CLEAR);

  bcd_score_counter #(.DIGITS(SCORE_DIGITS)) u_score (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (score_clr),
    .add_en    (brick_hit),
    .add_val   (level_q),
    .cmp_bcd   (best_cmp),
    .score_bcd (score),
    .gt        (score_gt)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      lives_q       <= 3'(LIVES);
      level_q       <= 4'd1;
      bricks_q      <= 6'(BRICKS_PER_LEVEL);
      timer_q       <= '0;
      field_reset_q <= 1'b0;
      serve_hold_q  <= 1'b1;
      game_over_q   <= 1'b0;
      victory_q     <= 1'b0;
      clear_q       <= 1'b0;
      start_prev    <= 1'b0;
      start_evt     <= 1'b0;
      launch_prev   <= 1'b0;
      launch_evt    <= 1'b0;
    end else begin
      start_prev    <= bus.start;
      start_evt     <= bus.start & ~start_prev;
      launch_prev   <= bus.launch;
      launch_evt    <= bus.launch & ~launch_prev;
      field_reset_q <= 1'b0;
      if (brick_hit) bricks_q <= bricks_q - 6'd1;
      if (in_banner) timer_q <= banner_done ? '0 : timer_q + TW'(bus.refresh_tick);

      case (state_q)
        IDLE: if (start_evt) begin
          state_q       <= SERVE;
          field_reset_q <= 1'b1;
        end
        SERVE: if (launch_evt) begin
          state_q      <= PLAY;
          serve_hold_q <= 1'b0;
        end
        PLAY: begin
          // Clearing the last brick beats a simultaneous ball loss.
          if (last_brick) begin
            serve_hold_q <= 1'b1;
            if (level_q == 4'(NUM_LEVELS)) begin
              state_q   <= VICTORY;
              victory_q <= 1'b1;
            end else begin
              state_q <= LEVEL_CLEAR;
              clear_q <= 1'b1;
            end
          end else if (bus.ball_died) begin
            serve_hold_q <= 1'b1;
            if (lives_q > 3'd1) begin
              lives_q <= lives_q - 3'd1;
              state_q <= SERVE;
            end else begin
              lives_q     <= 3'd0;
              state_q     <= GAME_OVER;
              game_over_q <= 1'b1;
            end
          end
        end
        LEVEL_CLEAR: if (banner_done) begin
          state_q       <= SERVE;
          level_q       <= level_q + 4'd1;
          bricks_q      <= 6'(BRICKS_PER_LEVEL);
          field_reset_q <= 1'b1;
          clear_q       <= 1'b0;
        end
        GAME_OVER, VICTORY: if (banner_done) begin
          state_q       <= IDLE;
          lives_q       <= 3'(LIVES);
          level_q       <= 4'd1;
          bricks_q      <= 6'(BRICKS_PER_LEVEL);
          field_reset_q <= 1'b1;
          game_over_q   <= 1'b0;
          victory_q     <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef HIGH_SCORE_EN
  // Power-up value only; the game reset leaves the best score alone.
  logic [SW-1:0] high_q = '0;

  always_ff @(posedge clk) begin
    if (((state_q == GAME_OVER) || (state_q == VICTORY)) && score_gt)
      high_q <= score;
  end

  assign best_cmp           = high_q;
  assign bus.high_score_bcd = high_q;
`else
  logic unused_score_gt;
  assign unused_score_gt    = score_gt;
  assign best_cmp           = '0;
  assign bus.high_score_bcd = '0;
`endif

  assign bus.state          = state_q;
  assign bus.field_reset    = field_reset_q;
  assign bus.serve_hold     = serve_hold_q;
  assign bus.lives          = lives_q;
  assign bus.level          = level_q;
  assign bus.score_bcd      = score;
  assign bus.game_over_on   = game_over_q;
  assign bus.victory_on     = victory_q;
  assign bus.level_clear_on = clear_q;

endmodule

// File: tb/tb_game_session_ctrl.sv
// Directed bench for game_session_ctrl: 3 lives, 4 bricks/level, 7 levels,
// 3-tick banners, 2 score digits so the score saturates on level 7.
module tb_game_session_ctrl;
  import game_pkg::*;

  localparam int SD = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   fr_cnt   = 0;

  logic [7:0] lvl_score [3] = '{8'h40, 8'h60, 8'h84};

  game_session_ctrl_if #(.SCORE_DIGITS(SD)) bus ();

  game_session_ctrl #(
    .LIVES            (3),
    .BRICKS_PER_LEVEL (4),
    .NUM_LEVELS       (7),
    .BANNER_TICKS     (3),
    .SCORE_DIGITS     (SD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // clock / reset-free pulse monitor
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.field_reset === 1'b1) fr_cnt++;

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step(2);
    chk("start_to_serve", bus.state, SERVE);
    bus.start = 1'b0;
    step(1);
  endtask

  task automatic do_launch();
    bus.launch = 1'b1;
    step(2);
    chk("launch_to_play", bus.state, PLAY);
    chk("launch_hold_low", bus.serve_hold, 1'b0);
    bus.launch = 1'b0;
    step(1);
  endtask

  task automatic brick();
    bus.brick_destroyed = 1'b1;
    step(1);
    bus.brick_destroyed = 1'b0;
  endtask

  task automatic ball();
    bus.ball_died = 1'b1;
    step(1);
    bus.ball_died = 1'b0;
  endtask

  initial begin
    bus.refresh_tick    = 1'b1;
    bus.start           = 1'b0;
    bus.launch          = 1'b0;
    bus.ball_died       = 1'b0;
    bus.brick_destroyed = 1'b0;

    // reset state
    step(2);
    chk("rst_state", bus.state, IDLE);
    chk("rst_lives", bus.lives, 3);
    chk("rst_level", bus.level, 1);
    chk("rst_score", bus.score_bcd, 0);
    chk("rst_hold", bus.serve_hold, 1'b1);
    chk("rst_banners", {bus.field_reset, bus.game_over_on, bus.victory_on, bus.level_clear_on}, 0);
    chk("rst_high", bus.high_score_bcd, 0);
    reset_n = 1'b1;
    step(1);

    // held start gives one field_reset
    bus.start = 1'b1;
    step(2);
    chk("start_state", bus.state, SERVE);
    chk("start_fr", bus.field_reset, 1'b1);
    step(3);
    bus.start = 1'b0;
    chk("start_fr_once", fr_cnt, 1);
    do_launch();

    // lives run out
    brick();
    chk("go_score1", bus.score_bcd, 8'h01);
    ball();
    chk("go_lives2", bus.lives, 2);
    chk("go_serve", bus.state, SERVE);
    chk("go_hold", bus.serve_hold, 1'b1);
    do_launch();
    ball();
    chk("go_lives1", bus.lives, 1);
    do_launch();
    ball();
    chk("go_lives0", bus.lives, 0);
    chk("go_state", bus.state, GAME_OVER);
    chk("go_banner", bus.game_over_on, 1'b1);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(1);
    chk("go_banner_last", bus.game_over_on, 1'b1);
    step(1);
    chk("go_to_idle", bus.state, IDLE);
    chk("go_banner_off", bus.game_over_on, 1'b0);
    chk("go_lives_reload", bus.lives, 3);
    chk("go_score_clr", bus.score_bcd, 0);
`ifdef HIGH_SCORE_EN
    chk("go_high", bus.high_score_bcd, 8'h01);
`else
    chk("go_high", bus.high_score_bcd, 0);
`endif
    step(2);
    chk("go_start_ignored", bus.state, IDLE);

    // level 1 and 2
    do_start();
    do_launch();
    repeat (4) brick();
    chk("l1_score", bus.score_bcd, 8'h04);
    chk("l1_state", bus.state, LEVEL_CLEAR);
    chk("l1_banner", bus.level_clear_on, 1'b1);
    brick();
    step(1);
    chk("l1_banner_brick", bus.score_bcd, 8'h04);
    step(1);
    chk("l1_serve", bus.state, SERVE);
    chk("l1_level2", bus.level, 2);
    chk("l1_banner_off", bus.level_clear_on, 1'b0);
    chk("l1_lives", bus.lives, 3);
    do_launch();
    repeat (3) brick();
    chk("l2_carry", bus.score_bcd, 8'h10);
    brick();
    chk("l2_score", bus.score_bcd, 8'h12);
    chk("l2_state", bus.state, LEVEL_CLEAR);
    step(3);
    chk("l2_level3", bus.level, 3);

    // last brick and ball loss together
    do_launch();
    repeat (3) brick();
    chk("l3_score", bus.score_bcd, 8'h21);
    bus.brick_destroyed = 1'b1;
    bus.ball_died       = 1'b1;
    step(1);
    bus.brick_destroyed = 1'b0;
    bus.ball_died       = 1'b0;
    chk("both_state", bus.state, LEVEL_CLEAR);
    chk("both_lives", bus.lives, 3);
    chk("both_score", bus.score_bcd, 8'h24);
    step(3);
    chk("l3_level4", bus.level, 4);

    // levels 4..6
    for (int k = 0; k < 3; k++) begin
      do_launch();
      repeat (4) brick();
      chk("lvl_state", bus.state, LEVEL_CLEAR);
      chk("lvl_score", bus.score_bcd, lvl_score[k]);
      step(3);
      chk("lvl_next", bus.level, k + 5);
    end

    // level 7 saturates then wins
    do_launch();
    repeat (2) brick();
    chk("l7_98", bus.score_bcd, 8'h98);
    brick();
    chk("l7_sat", bus.score_bcd, 8'h99);
    brick();
    chk("vic_state", bus.state, VICTORY);
    chk("vic_banner", bus.victory_on, 1'b1);
    chk("vic_clear_off", bus.level_clear_on, 1'b0);
    chk("vic_score", bus.score_bcd, 8'h99);
    step(1);
    reset_n = 1'b0;
    step(1);
    chk("vrst_state", bus.state, IDLE);
    chk("vrst_banner", bus.victory_on, 1'b0);
    chk("vrst_score", bus.score_bcd, 0);
    chk("vrst_level", bus.level, 1);
`ifdef HIGH_SCORE_EN
    chk("vrst_high", bus.high_score_bcd, 8'h99);
`else
    chk("vrst_high", bus.high_score_bcd, 0);
`endif
    reset_n = 1'b1;
    step(2);
    chk("end_idle", bus.state, IDLE);
    chk("fr_total", fr_cnt, 9);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_session_ctrl.md
Name: game_session_ctrl

Overview:
Parametrised game-session sequencer for the Breakout top level. It replaces the ad-hoc lives, game-over, victory and auto-reset glue with one FSM, and adds multi-level play, a level-scaled BCD score and timed banners. It sits between the ball and brick_array collision pulses and the display overlays, HEX decoders and field-reset fan-out.

Parameters:
LIVES, 3, lives granted per game (1..7)
BRICKS_PER_LEVEL, 28, bricks loaded per level (1..63)
NUM_LEVELS, 3, levels per game (1..9); clearing the last level is victory
BANNER_TICKS, 360, banner duration in refresh_tick pulses (2 s at 180 Hz)
SCORE_DIGITS, 3, BCD score digits (2..4)

Ports:
clk  in  1  system clock (CLOCK_50 at top)
reset_n  in  1  synchronous active-low reset
refresh_tick  in  1  1-cycle game-rate strobe
start  in  1  debounced start button, level-sensitive
launch  in  1  debounced up button, level-sensitive
ball_died  in  1  1-cycle pulse, ball left the bottom edge
brick_destroyed  in  1  1-cycle pulse, one brick removed
state  out  3  current FSM state (package enum)
field_reset  out  1  1-cycle pulse: reload bricks, re-centre paddle and ball
serve_hold  out  1  ball held on paddle
lives  out  3  lives remaining
level  out  4  current level, 1-based
score_bcd  out  4*SCORE_DIGITS  packed BCD score, digit 0 in LSBs
game_over_on  out  1  game-over banner active
victory_on  out  1  victory banner active
level_clear_on  out  1  level-clear banner active
high_score_bcd  out  4*SCORE_DIGITS  best score since power-up (see Optional Feature)

Behaviour:
- Reset (reset_n=0 at clk edge) state=IDLE, lives=LIVES, level=1, score=0, bricks_left=BRICKS_PER_LEVEL, banner timer=0. All pulse and banner outputs are 0. serve_hold=1. Reset mid-banner aborts the banner immediately.
- start and launch are rising-edge detected internally with a 1-cycle registered delay. Holding a button produces exactly one event.
- IDLE: start edge -> field_reset pulse, go to SERVE.
- SERVE: serve_hold=1. launch edge -> PLAY, serve_hold=0 on the next cycle.
- PLAY:
  - brick_destroyed: bricks_left decrements and the score gains `level` points through a BCD add with ripple carry. The score saturates at all-9s and never wraps.
  - When bricks_left goes 1->0: enter VICTORY if level==NUM_LEVELS, otherwise LEVEL_CLEAR.
  - ball_died: if lives>1, decrement lives, pulse field_reset-free serve (ball only, bricks kept), go to SERVE, serve_hold=1. If lives==1, set lives=0 and go to GAME_OVER.
  - ball_died and the last brick_destroyed in the same cycle: the clear wins, lives are unchanged, and the score still increments.
  - Pulses arriving in any other state are ignored.
  - brick_destroyed while bricks_left==0 is ignored.
- LEVEL_CLEAR: level_clear_on=1. The timer counts refresh_tick up to BANNER_TICKS. On expiry, in a single cycle: level+1, bricks_left reload, field_reset pulse, go to SERVE. Lives carry over.
- GAME_OVER / VICTORY: the matching banner is 1 while the timer runs. On expiry: field_reset pulse, lives/level/score/bricks reset as in reset, go to IDLE. start is ignored during banners.
- Banner outputs are mutually exclusive and registered. They assert on the cycle the state is entered.
- Latency: pulse input -> counter/state update 1 cycle. Button edge -> state change 2 cycles.

Optional Feature:
HIGH_SCORE_EN
- Defined: a high-score register, 0 at power-up and NOT cleared by reset_n. On entry to GAME_OVER or VICTORY it loads the score if the score is greater (BCD magnitude compare). Drives high_score_bcd.
- Undefined: the register is absent and high_score_bcd is tied to 0.

Decomposition:
- Package game_pkg holds:
  - the state enum: IDLE, SERVE, PLAY, LEVEL_CLEAR, GAME_OVER, VICTORY
  - the BCD digit typedef
  - the 7-segment digit_to_seg function, shared with the top level
- Sub-module bcd_score_counter(SCORE_DIGITS) provides saturating add of a 1-digit value, clear, and compare.

Test Plan:
- Reset, start edge, launch edge -> field_reset pulse once; state IDLE->SERVE->PLAY; lives=3, level=1, score=000.
- LIVES=3, 3 ball_died pulses in PLAY with a launch between each -> lives 2,1,0; third pulse enters GAME_OVER, game_over_on high for 360 ticks, then IDLE with score=000, lives=3.
- BRICKS_PER_LEVEL=4, NUM_LEVELS=2: 4 brick pulses -> score=004, LEVEL_CLEAR; after banner level=2; 4 more -> score=012, VICTORY, victory_on high.
- Final brick_destroyed and ball_died in the same cycle -> LEVEL_CLEAR, lives unchanged, score incremented.
- SCORE_DIGITS=2, preload 98, level 3 brick pulse -> score saturates at 99.
- Assert reset_n mid-VICTORY banner -> next cycle victory_on=0, state IDLE. With HIGH_SCORE_EN, high_score_bcd retains the prior best.
